// File: rtl/div_unit_if.sv
// div_unit_if: request/response handshake bundle for the divider.
// master = issue/writeback side, slave = divider.
interface div_unit_if #(
  parameter int REG_WIDTH = 32
);
  logic                 i_req_valid;
  logic                 o_req_ready;
  logic [1:0]           i_op;
  logic [REG_WIDTH-1:0] i_rs1;
  logic [REG_WIDTH-1:0] i_rs2;
  logic [4:0]           i_rd;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready;
  logic [REG_WIDTH-1:0] o_result;
  logic [4:0]           o_rd;
  logic                 o_busy;

  modport master (
    output i_req_valid, i_op, i_rs1, i_rs2, i_rd,
    output i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_result,
    input  o_rd, o_busy
  );

  modport slave (
    input  i_req_valid, i_op, i_rs1, i_rs2, i_rd,
    input  i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_result,
    output o_rd, o_busy
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; div-by-zero and signed overflow finish early.
module div_unit #(
  parameter int REG_WIDTH = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  div_unit_if.slave  io_div
);
  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(REG_WIDTH);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_op;
  logic [4:0]    r_rd;
  logic          r_neg_q, r_neg_r;
  logic [W-1:0]  r_rem, r_quo, r_div;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_result;

  logic          w_acc, w_signed, w_s1n, w_s2n;
  logic          w_div0, w_ovf, w_special;
  logic [W-1:0]  w_a_abs, w_b_abs, w_spec_res;
  logic [W:0]    w_shr, w_trial;
  logic [W-1:0]  w_rem_nx, w_quo_nx, w_fix;

  assign io_div.o_req_ready = (r_state == IDLE) & i_rst_n;
  assign io_div.o_rsp_valid = (r_state == DONE);
  assign io_div.o_busy      = (r_state != IDLE);
  assign io_div.o_result    = r_result;
  assign io_div.o_rd        = r_rd;

  assign w_acc    = io_div.i_req_valid & io_div.o_req_ready & ~i_flush;
  assign w_signed = ~io_div.i_op[0];
  assign w_s1n    = w_signed & io_div.i_rs1[W-1];
  assign w_s2n    = w_signed & io_div.i_rs2[W-1];
  assign w_a_abs  = w_s1n ? -io_div.i_rs1 : io_div.i_rs1;
  assign w_b_abs  = w_s2n ? -io_div.i_rs2 : io_div.i_rs2;

  assign w_div0    = (io_div.i_rs2 == '0);
  assign w_ovf     = w_signed & (io_div.i_rs1 == MIN) & (&io_div.i_rs2);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_spec_res = io_div.i_rs1;
    if (io_div.i_op[1]) begin
      w_spec_res = w_div0 ? io_div.i_rs1 : '0;
    end else if (w_div0) begin
      w_spec_res = '1;
    end
  end

  // trial subtract is W+1 bits: shifted remainder can exceed W bits
  assign w_shr    = {r_rem, r_quo[W-1]};
  assign w_trial  = w_shr - {1'b0, r_div};
  assign w_rem_nx = w_trial[W] ? w_shr[W-1:0] : w_trial[W-1:0];
  assign w_quo_nx = {r_quo[W-2:0], ~w_trial[W]};

  always_comb begin
    w_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    if (r_op[1]) begin
      w_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (w_acc) w_state_nx = w_special ? DONE : BUSY;
      BUSY: if (r_cnt == '0) w_state_nx = DONE;
      DONE: if (io_div.i_rsp_ready) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (i_flush) w_state_nx = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_acc) begin
      r_op    <= io_div.i_op;
      r_rd    <= io_div.i_rd;
      r_neg_q <= w_s1n ^ w_s2n;
      r_neg_r <= w_s1n;
      r_rem   <= '0;
      r_quo   <= w_a_abs;
      r_div   <= w_b_abs;
      r_cnt   <= CW'(REG_WIDTH - 1);
      if (w_special) r_result <= w_spec_res;
    end else if (r_state == BUSY && !i_flush) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == '0) r_result <= w_fix;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit.
// Latency counted from the accept edge to the first valid cycle.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  div_unit_if #(.REG_WIDTH(32)) bus ();

  div_unit #(.REG_WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .io_div  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.i_op = op;
    bus.i_rs1 = a;
    bus.i_rs2 = b;
    bus.i_rd = rd;
    bus.i_req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_op = ~op;
    bus.i_rs1 = ~a;
    bus.i_rs2 = b + 32'd5;
    bus.i_rd = ~rd;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.o_rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp,
                     input int lat);
    int n;
    start(op, a, b, rd);
    chk({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
    wait_valid(n);
    chk({tag, ".lat"}, n, lat);
    chk(tag, bus.o_result, exp);
    chk({tag, ".rd"}, 32'(bus.o_rd), 32'(rd));
    @(posedge clk);
    #1;
    chk({tag, ".drop"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({tag, ".rdy"}, 32'(bus.o_req_ready), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    bus.i_req_valid = 1'b0;
    bus.i_op = 2'b00;
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    bus.i_rd = '0;
    bus.i_rsp_ready = 1'b1;

    #12;
    chk("rst.valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst.busy", 32'(bus.o_busy), 32'd0);
    chk("rst.result", bus.o_result, 32'd0);
    chk("rst.rd", 32'(bus.o_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.ready", 32'(bus.o_req_ready), 32'd1);

    run("divu", DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    run("remu", REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33);
    run("div_n7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
    run("rem_n7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
    run("rem_7_n2", REM, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 33);
    run("div_big", DIVU, 32'hFFFF_FFFF, 32'd16, 5'd8, 32'h0FFF_FFFF, 33);
    run("div0", DIV, 32'h1234_5678, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    run("remu0", REMU, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    run("ovf_div", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
        32'h8000_0000, 1);
    run("ovf_rem", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);

    bus.i_rsp_ready = 1'b0;
    start(DIV, 32'hFFFF_FFF9, 32'd2, 5'd13);
    wait_valid(n);
    chk("bp.lat", n, 33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.valid", 32'(bus.o_rsp_valid), 32'd1);
      chk("bp.result", bus.o_result, 32'hFFFF_FFFD);
      chk("bp.rd", 32'(bus.o_rd), 32'd13);
      chk("bp.busy", 32'(bus.o_busy), 32'd1);
      chk("bp.ready", 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.rel_ready", 32'(bus.o_req_ready), 32'd1);
    chk("bp.rel_valid", 32'(bus.o_rsp_valid), 32'd0);

    start(DIVU, 32'd1000, 32'd3, 5'd14);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_op = DIVU;
    bus.i_rs1 = 32'd50;
    bus.i_rs2 = 32'd5;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.i_req_valid = 1'b0;
    chk("fl.busy", 32'(bus.o_busy), 32'd0);
    chk("fl.valid", 32'(bus.o_rsp_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_rsp_valid || bus.o_busy) seen++;
    end
    chk("fl.quiet", seen, 0);
    run("fl.next", DIVU, 32'd9, 32'd3, 5'd15, 32'd3, 33);

    bus.i_rsp_ready = 1'b0;
    start(DIVU, 32'd5, 32'd0, 5'd2);
    chk("fld.valid", 32'(bus.o_rsp_valid), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.i_rsp_ready = 1'b1;
    chk("fld.drop", 32'(bus.o_rsp_valid), 32'd0);
    chk("fld.busy", 32'(bus.o_busy), 32'd0);

    start(DIVU, 32'd100, 32'd7, 5'd21);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("arst.busy", 32'(bus.o_busy), 32'd0);
    chk("arst.result", bus.o_result, 32'd0);
    chk("arst.rd", 32'(bus.o_rd), 32'd0);
    chk("arst.ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst.rel_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("arst.rel_ready", 32'(bus.o_req_ready), 32'd1);
    run("arst.next", DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 33);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider that implements RISC-V M-extension DIV/DIVU/REM/REMU.
- Sits in the execute stage beside the single-cycle alu, which has no divide path.
- Issue logic hands it operands through a valid/ready request port. The result returns through a valid/ready response port toward writeback.
- The stall logic in execute holds the pipeline while the unit is busy.

Parameters:
- REG_WIDTH, 32: operand and result width. Must be a power of two, at least 8.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous abort of any in-flight or held operation
- i_req_valid  in  1  request valid
- o_req_ready  out  1  unit can accept a request
- i_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_rs1  in  REG_WIDTH  dividend
- i_rs2  in  REG_WIDTH  divisor
- i_rd  in  5  destination register tag, carried to the output
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  consumer accepts result
- o_result  out  REG_WIDTH  quotient or remainder, per the latched op
- o_rd  out  5  tag of the request that produced o_result
- o_busy  out  1  high in BUSY or DONE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state IDLE; o_rsp_valid=0; o_result=0; o_rd=0; o_busy=0; all internal registers 0. o_req_ready=1 once reset is released.
- FSM states are IDLE, BUSY and DONE.
- o_req_ready is 1 only in IDLE. Accept happens on i_req_valid && o_req_ready at a rising edge.
- On accept, latch op, rd, sign flags and the absolute values of the operands. The unsigned ops and DIVU/REMU take operands raw.
- Special cases, which skip BUSY and go straight to DONE one cycle after accept:
  - divisor=0: quotient = all ones, remainder = dividend.
  - signed op with dividend = most-negative and divisor = -1: quotient = dividend, remainder = 0.
- Normal case goes to BUSY with iteration counter = REG_WIDTH-1. Each cycle:
  - shift {rem, quo} left by 1;
  - trial = rem - divisor (REG_WIDTH+1 bits);
  - if trial is non-negative, rem = trial and quo LSB = 1.
- Counter decrements each cycle. When it is 0 at a clock edge, go to DONE with the sign fixup applied:
  - quotient is negated when the dividend and divisor signs differ (signed ops only);
  - remainder takes the dividend's sign.
- Latency: accept edge to the first cycle o_rsp_valid=1 is REG_WIDTH+1 cycles normally, and 1 cycle for special cases.
- DONE: o_rsp_valid=1. o_result and o_rd stay stable until i_rsp_ready=1 at an edge, then go to IDLE.
- o_rsp_valid drops in the cycle after handshake. A new request cannot be accepted in that same edge; the earliest accept is the next edge (no back-to-back overlap).
- i_flush has priority over everything else. At the next edge the FSM goes to IDLE and o_rsp_valid=0. A request presented together with i_flush is not accepted.
- An edge with i_flush=1 in DONE discards the result with no handshake.
- Asynchronous reset mid-operation returns the unit to the reset values immediately, with no output glitch after reset is released.
- Inputs are sampled only at accept. Changes to i_rs1, i_rs2, i_op or i_rd while BUSY have no effect.
- Arithmetic is unsigned on magnitudes. Negation is two's complement within REG_WIDTH.

Test Plan:
- Normal DIVU: DIVU 100/7 with i_rsp_ready=1 → o_rsp_valid exactly 33 cycles after accept, o_result=14. Repeat as REMU → 2.
- Signed sign fixup: DIV -7/2 → 0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). REM 7/-2 → 1.
- Divide by zero: DIV 0x12345678/0 → 0xFFFFFFFF after 1 cycle. REMU 5/0 → 5.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM on the same operands → 0. Both after 1 cycle.
- Backpressure: hold i_rsp_ready=0 for 10 cycles after o_rsp_valid → o_result, o_rd and o_busy stable, o_req_ready=0. Release → o_req_ready=1 one cycle later.
- Flush and reset: pulse i_flush at iteration 10 → next cycle IDLE, no o_rsp_valid, next DIVU 9/3 → 3. Assert i_rst_n=0 mid-BUSY → all outputs immediately 0.
